// File: rtl/led_send_sched.sv
// led_send_sched: schedules 128-bit frames from two requesters onto a single
// LED_send channel. A round-robin arbiter accepts a frame in IDLE, then the
// block holds tx_enable high for EN_CYCLES clocks (LOAD) and waits TX_CYCLES
// clocks (WAIT) while LED_send shifts the frame out.
//
// Optional feature: define LED_SCHED_REFRESH_EN to re-send the last frame
// (grant_id = 2'b10) after REFRESH_CYCLES idle clocks with no pending request.
//
// Ports:
//   clk                    single clock
//   rstn                   asynchronous active-low reset
//   req0_valid, req1_valid requester N offers a frame
//   req0_data,  req1_data  frame from requester N
//   req0_ready, req1_ready frame from requester N accepted this cycle
//   tx_enable              LED_send enable
//   tx_data                LED_send data_in (last accepted frame)
//   busy                   high in LOAD and WAIT
//   grant_id               source of current/last frame: 00 req0, 01 req1, 10 refresh
module led_send_sched #(
  parameter int unsigned EN_CYCLES      = 15,
  parameter int unsigned TX_CYCLES      = 2100,
  parameter int unsigned REFRESH_CYCLES = 150000
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req0_valid,
  input  logic         req1_valid,
  input  logic [127:0] req0_data,
  input  logic [127:0] req1_data,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic         tx_enable,
  output logic [127:0] tx_data,
  output logic         busy,
  output logic [1:0]   grant_id
);

  if (EN_CYCLES < 1 || TX_CYCLES < 1 || REFRESH_CYCLES < 1) begin : g_param_check
    $error("led_send_sched: cycle parameters must be at least 1");
  end

  localparam int unsigned CNT_MAX = (EN_CYCLES > TX_CYCLES) ? EN_CYCLES : TX_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] EN_LAST = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_prio_q;     // 0: req0 preferred on a tie, 1: req1 preferred
  logic             sel1;          // arbiter picks req1
  logic             take_req;      // handshake this cycle
  logic             take_refresh;  // refresh re-send starts this cycle
  logic             refresh_hit;

  assign sel1 = req1_valid && (!req0_valid || rr_prio_q);

  // Ready is gated by rstn so both readys stay low while reset is held.
  assign req0_ready = rstn && (state_q == IDLE) && req0_valid && !sel1;
  assign req1_ready = rstn && (state_q == IDLE) && sel1;
  assign tx_enable  = (state_q == LOAD);
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    take_req     = 1'b0;
    take_refresh = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A pending request always wins over a refresh reaching threshold.
        if (req0_valid || req1_valid) begin
          take_req = 1'b1;
          state_d  = LOAD;
        end else if (refresh_hit) begin
          take_refresh = 1'b1;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q == EN_LAST) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (cnt_q == TX_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_prio_q <= 1'b0;
      tx_data   <= '0;
      grant_id  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take_req) begin
        tx_data   <= sel1 ? req1_data : req0_data;
        grant_id  <= {1'b0, sel1};
        rr_prio_q <= !sel1;
      end else if (take_refresh) begin
        grant_id <= 2'b10;
      end
    end
  end

`ifdef LED_SCHED_REFRESH_EN
  localparam int unsigned IDLE_W = $clog2(REFRESH_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(REFRESH_CYCLES);

  logic [IDLE_W-1:0] idle_cnt_q;
  logic              frame_valid_q;

  assign refresh_hit = frame_valid_q && (idle_cnt_q == IDLE_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt_q    <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      if (take_req) begin
        frame_valid_q <= 1'b1;
      end
      if (state_q != IDLE || take_req || take_refresh) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != IDLE_MAX) begin
        idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
      end
    end
  end
`else
  assign refresh_hit = 1'b0;
`endif

endmodule

// File: tb/tb_led_send_sched.sv
// Testbench for led_send_sched (EN_CYCLES=3, TX_CYCLES=10, REFRESH_CYCLES=20).
// Table-driven directed vectors, hand-written multi-cycle sequences, and a
// randomized run compared against a countdown-based reference model.
// Refresh checks follow LED_SCHED_REFRESH_EN.
module tb_led_send_sched;

  localparam int EN = 3;
  localparam int TX = 10;
  localparam int RF = 20;
`ifdef LED_SCHED_REFRESH_EN
  localparam bit REFRESH_ON = 1'b1;
`else
  localparam bit REFRESH_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [127:0] req0_data = '0, req1_data = '0;
  logic         req0_ready, req1_ready, tx_enable, busy;
  logic [127:0] tx_data;
  logic [1:0]   grant_id;

  led_send_sched #(
    .EN_CYCLES     (EN),
    .TX_CYCLES     (TX),
    .REFRESH_CYCLES(RF)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req0_valid(req0_valid),
    .req1_valid(req1_valid),
    .req0_data (req0_data),
    .req1_data (req1_data),
    .req0_ready(req0_ready),
    .req1_ready(req1_ready),
    .tx_enable (tx_enable),
    .tx_data   (tx_data),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] DA = {4{32'h5555_5555}};
  localparam logic [127:0] DB = {4{32'hA5C3_0F96}};
  localparam logic [127:0] DC = {4{32'h0123_4567}};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         v0, v1;
    logic [127:0] d0, d1;
    logic         r0, r1, en, bz;
    logic [1:0]   g;
    logic [127:0] data;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v0, input logic v1, input logic [127:0] d0,
                              input logic [127:0] d1, input logic r0, input logic r1,
                              input logic en, input logic bz, input logic [1:0] g,
                              input logic [127:0] data);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.en = en; v.bz = bz; v.g = g; v.data = data;
    tbl.push_back(v);
  endfunction

  // ---------------- reference model ----------------
  int           m_rem;   // busy clocks remaining in the current frame
  int           m_idle;  // consecutive idle clocks seen
  bit           m_prio;  // requester preferred on the next tie
  bit           m_fv;    // a frame has been accepted since reset
  logic [127:0] m_data;
  logic [1:0]   m_grant;

  task automatic model_reset();
    m_rem = 0; m_idle = 0; m_prio = 1'b0; m_fv = 1'b0; m_data = '0; m_grant = 2'b00;
  endtask

  task automatic model_check(input int cyc);
    bit idle, e0, e1;
    idle = (m_rem == 0);
    e0 = idle && req0_valid && (!req1_valid || m_prio == 1'b0);
    e1 = idle && req1_valid && (!req0_valid || m_prio == 1'b1);
    chk($sformatf("rnd%0d.ctl{r0,r1,en,busy,grant}", cyc),
        {req0_ready, req1_ready, tx_enable, busy, grant_id},
        {e0, e1, (m_rem > TX), !idle, m_grant});
    chk($sformatf("rnd%0d.tx_data", cyc), tx_data, m_data);
  endtask

  task automatic model_step();
    bit p;
    if (m_rem == 0) begin
      if (req0_valid || req1_valid) begin
        p       = req1_valid && (!req0_valid || m_prio);
        m_data  = p ? req1_data : req0_data;
        m_grant = {1'b0, p};
        m_prio  = !p;
        m_rem   = EN + TX;
        m_idle  = 0;
        m_fv    = 1'b1;
      end else if (REFRESH_ON && m_fv && m_idle == RF) begin
        m_grant = 2'b10;
        m_rem   = EN + TX;
        m_idle  = 0;
      end else if (m_idle < RF) begin
        m_idle++;
      end
    end else begin
      m_rem--;
    end
  endtask

  // ---------------- helpers ----------------
  // Holds reset with both valids high (readys must still be 0), checks the
  // reset values, then releases on a falling edge and parks at posedge+1.
  task automatic apply_reset(input string tag);
    rstn = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, ".rst_ctl{r0,r1,en,busy,grant}"},
        {req0_ready, req1_ready, tx_enable, busy, grant_id}, 6'b0);
    chk({tag, ".rst_data"}, tx_data, '0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive busy clocks; ends just after the negedge of the first idle clock.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  // Called in an idle clock (after its negedge); counts idle clocks until busy.
  task automatic count_idle(input int lim, output int n);
    n = 1;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (busy) break;
      n++;
    end
  endtask

  task automatic send0(input logic [127:0] d, input string tag);
    req0_valid = 1'b1; req0_data = d;
    @(negedge clk);
    chk({tag, ".accept_r0"}, req0_ready, 1'b1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    int n;
    int seen;
    int den;
    model_reset();
    apply_reset("t0");

    // single frame from req0
    add(1, 0, DA, DB, 1, 0, 0, 0, 2'b00, '0);
    for (int i = 0; i < EN; i++) add(0, 0, DA, DB, 0, 0, 1, 1, 2'b00, DA);
    for (int i = 0; i < TX; i++) add(0, 0, DA, DB, 0, 0, 0, 1, 2'b00, DA);
    // contention: req1 wins after req0, valids held through busy
    add(1, 1, DC, DB, 0, 1, 0, 0, 2'b00, DA);
    for (int i = 0; i < EN; i++) add(1, 1, DC, DB, 0, 0, 1, 1, 2'b01, DB);
    for (int i = 0; i < TX; i++) add(1, 1, DC, DB, 0, 0, 0, 1, 2'b01, DB);
    add(1, 1, DC, DB, 1, 0, 0, 0, 2'b01, DB);
    for (int i = 0; i < EN; i++) add(0, 0, DC, DB, 0, 0, 1, 1, 2'b00, DC);
    for (int i = 0; i < TX; i++) add(0, 0, DC, DB, 0, 0, 0, 1, 2'b00, DC);
    add(0, 0, DC, DB, 0, 0, 0, 0, 2'b00, DC);

    foreach (tbl[i]) begin
      req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
      req0_data  = tbl[i].d0; req1_data  = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("vec%0d.ctl{r0,r1,en,busy,grant}", i),
          {req0_ready, req1_ready, tx_enable, busy, grant_id},
          {tbl[i].r0, tbl[i].r1, tbl[i].en, tbl[i].bz, tbl[i].g});
      chk($sformatf("vec%0d.tx_data", i), tx_data, tbl[i].data);
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // hold during busy: req1 raised in the 2nd WAIT clock waits until IDLE
    apply_reset("hold");
    send0(DA, "hold");
    repeat (EN + 1) begin
      @(posedge clk);
      #1;
    end
    req1_valid = 1'b1; req1_data = DB;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req1_ready) break;
      n++;
      @(posedge clk);
      #1;
    end
    chk("hold.wait_clocks", n, TX - 1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("hold.grant", grant_id, 2'b01);
    chk("hold.data", tx_data, DB);
    chk("hold.en", tx_enable, 1'b1);

    // frame length and reset in the 2nd LOAD clock
    apply_reset("len");
    send0(DA, "len");
    count_busy(n);
    chk("len.busy_clocks", n, EN + TX);

    apply_reset("abort");
    send0(DC, "abort");
    @(posedge clk);
    #1;
    chk("abort.en_before", tx_enable, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("abort.async{en,busy,grant}", {tx_enable, busy, grant_id}, 4'b0);
    chk("abort.async_data", tx_data, '0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy || tx_enable || req0_ready || req1_ready) seen++;
    end
    chk("abort.quiet_after_release", seen, 0);
    @(posedge clk);
    #1;

    // refresh after idle interval, or none when the feature is absent
    apply_reset("refresh");
    send0(DA, "refresh");
    count_busy(n);
    count_idle(119, n);
    if (REFRESH_ON) begin
      chk("refresh.idle_clocks", n, RF + 1);
      chk("refresh.grant", grant_id, 2'b10);
      chk("refresh.en", tx_enable, 1'b1);
      chk("refresh.data", tx_data, DA);
    end else begin
      chk("norefresh.idle_clocks", n, 120);
      chk("norefresh.grant", grant_id, 2'b00);
    end

    // request arriving exactly at the refresh threshold beats refresh
    apply_reset("tie");
    send0(DA, "tie");
    count_busy(n);
    repeat (RF) begin
      @(posedge clk);
      #1;
    end
    req1_valid = 1'b1; req1_data = DB;
    @(negedge clk);
    chk("tie.r1", {req1_ready, busy}, 2'b10);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("tie.grant", grant_id, 2'b01);
    chk("tie.data", tx_data, DB);
    @(posedge clk);
    #1;
    count_busy(n);
    chk("tie.busy_clocks", n, EN + TX - 1);
    count_idle(119, n);
    chk("tie.idle_restart", n, REFRESH_ON ? RF + 1 : 120);

    // randomized run against the reference model
    apply_reset("rnd");
    model_reset();
    for (int c = 0; c < 900; c++) begin
      case ((c / 150) % 3)
        0: den = 3;
        1: den = 8;
        default: den = 40;
      endcase
      if (req0_valid) begin
        if ($urandom_range(0, 7) == 0) req0_valid = 1'b0;
      end else if ($urandom_range(0, den - 1) == 0) begin
        req0_valid = 1'b1;
        req0_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      if (req1_valid) begin
        if ($urandom_range(0, 7) == 0) req1_valid = 1'b0;
      end else if ($urandom_range(0, den - 1) == 0) begin
        req1_valid = 1'b1;
        req1_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      model_check(c);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
